// File: rtl/pps_lock_supervisor.sv
// PPS lock supervisor: measures the White Rabbit PPS period, tracks lock, and
// flywheels a synthetic PPS for a bounded number of seconds after the reference is lost.
module pps_lock_supervisor #(
  parameter int unsigned EXPECTED_CYCLES = 62500000,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned HOLDOVER_MAX    = 10
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        pps_i,
  input  logic        clear_i,
  output logic        pps_o,
  output logic [1:0]  state_o,
  output logic        locked_o,
  output logic [31:0] period_o,
  output logic        period_valid_o,
  output logic [15:0] err_count_o,
  output logic [31:0] sec_count_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  localparam logic [31:0] EXP    = 32'(EXPECTED_CYCLES);
  localparam logic [31:0] LO     = 32'(EXPECTED_CYCLES - TOLERANCE);
  localparam logic [31:0] HI     = 32'(EXPECTED_CYCLES + TOLERANCE);
  localparam logic [31:0] TMO    = 32'(EXPECTED_CYCLES + TOLERANCE + 1);
  localparam logic [31:0] TOL    = 32'(TOLERANCE);
  localparam logic [15:0] LOCK_N = 16'(LOCK_COUNT);
  localparam logic [15:0] HO_N   = 16'(HOLDOVER_MAX);

  state_t      state, state_n;
  logic        pps_d;
  logic [31:0] cnt, ph;
  logic [15:0] good_cnt, ho_cnt;

  logic pps_edge, timeout, wrap, good, aligned;
  logic measure, good_inc, good_clr, ho_inc, ho_clr, err_inc, emit_wrap, pulse;

  assign pps_edge = pps_i & ~pps_d;
  assign timeout  = ~pps_edge && (cnt == TMO);
  assign wrap     = (ph == EXP);
  assign good     = (cnt >= LO) && (cnt <= HI);
  assign aligned  = (ph <= TOL) || (ph >= LO);
  assign pulse    = pps_edge | emit_wrap;
  assign state_o  = state;

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    measure   = 1'b0;
    good_inc  = 1'b0;
    good_clr  = 1'b0;
    ho_inc    = 1'b0;
    ho_clr    = 1'b0;
    err_inc   = 1'b0;
    emit_wrap = 1'b0;
    case (state)
      IDLE: begin
        if (pps_edge) begin
          state_n  = ACQUIRE;
          good_clr = 1'b1;
        end
      end
      ACQUIRE: begin
        if (pps_edge) begin
          measure = 1'b1;
          if (good) begin
            good_inc = 1'b1;
            if (good_cnt + 16'd1 >= LOCK_N) state_n = LOCKED;
          end else begin
            good_clr = 1'b1;
          end
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (pps_edge) begin
          measure = 1'b1;
          if (!good) begin
            state_n  = ACQUIRE;
            good_clr = 1'b1;
            err_inc  = 1'b1;
          end
        end else if (timeout) begin
          state_n = HOLDOVER;
          ho_clr  = 1'b1;
          err_inc = 1'b1;
        end
      end
      HOLDOVER: begin
        // A returning edge is judged by phase against the flywheel, not by period.
        if (pps_edge) begin
          measure = 1'b1;
          if (aligned) begin
            state_n = LOCKED;
          end else begin
            state_n  = ACQUIRE;
            good_clr = 1'b1;
          end
        end else if (wrap) begin
          emit_wrap = 1'b1;
          ho_inc    = 1'b1;
          if (ho_cnt + 16'd1 >= HO_N) begin
            state_n = IDLE;
            err_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge reset_i) begin
    if (reset_i) begin
      pps_d          <= 1'b1;  // a level already high at release is not an edge
      cnt            <= '0;
      ph             <= '0;
      good_cnt       <= '0;
      ho_cnt         <= '0;
      pps_o          <= 1'b0;
      locked_o       <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      err_count_o    <= '0;
      sec_count_o    <= '0;
    end else begin
      pps_d <= pps_i;

      if (pps_edge)        cnt <= 32'd1;
      else if (cnt != '1)  cnt <= cnt + 32'd1;

      if (pps_edge || wrap) ph <= 32'd1;
      else                  ph <= ph + 32'd1;

      if (good_clr)      good_cnt <= '0;
      else if (good_inc) good_cnt <= good_cnt + 16'd1;

      if (ho_clr)      ho_cnt <= '0;
      else if (ho_inc) ho_cnt <= ho_cnt + 16'd1;

      period_valid_o <= measure;
      if (measure) period_o <= cnt;

      pps_o    <= pulse;
      locked_o <= (state_n == LOCKED);

      if (clear_i)                         err_count_o <= '0;
      else if (err_inc && err_count_o != '1) err_count_o <= err_count_o + 16'd1;

      if (clear_i)    sec_count_o <= '0;
      else if (pulse) sec_count_o <= sec_count_o + 32'd1;
    end
  end

endmodule
